div_issue_ctrl: RTL and testbench

- Controller that shares the single iterative divider between the two issue lanes of the superscalar EX stage.
- Per request: arbitrates round-robin, latches operands/op/destination tag, sequences the divider start/finish handshake, buffers the result for writeback with valid/ready, and squashes in-flight work on pipeline flush.
- Sits between the EX issue buffers and the writeback arbiter.
- Uses alu_op_type and XLEN_WIDTH from common.

---
 rtl/common.sv | 26 ++
 rtl/div_issue_ctrl_if.sv | 35 +++
 rtl/div_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared definitions for the EX stage.
//   XLEN_WIDTH  : integer datapath width
//   alu_op_type : ALU/divider operation encoding
package common;

    localparam int unsigned XLEN_WIDTH = 32;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_type;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request/writeback bus between the EX issue lanes, the divide issue
// controller and the writeback arbiter.
//   req_valid/req_ready : per-lane request handshake (2 lanes)
//   req_op/a/b/tag      : per-lane operation, dividend, divisor, dest tag
//   wb_valid/wb_ready   : result handshake towards writeback
//   wb_tag/wb_data      : result tag and data
// Modports: master = issue/writeback side, slave = controller.
interface div_issue_ctrl_if #(
    parameter int unsigned TAG_W = 6
);
    import common::*;

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    alu_op_type            req_op  [2];
    logic [XLEN_WIDTH-1:0] req_a   [2];
    logic [XLEN_WIDTH-1:0] req_b   [2];
    logic [TAG_W-1:0]      req_tag [2];

    logic                  wb_valid;
    logic                  wb_ready;
    logic [TAG_W-1:0]      wb_tag;
    logic [XLEN_WIDTH-1:0] wb_data;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, wb_ready,
        input  req_ready, wb_valid, wb_tag, wb_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, wb_ready,
        output req_ready, wb_valid, wb_tag, wb_data
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// Shares one iterative divider between the two EX issue lanes: round-robin
// grant, operand latch, divider start/finish sequencing, result buffering
// for writeback, and squash of in-flight work on flush.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   flush                : pipeline flush, kills pending/in-flight work
//   bus (slave)          : request lanes + writeback handshake
//   div_start/div_op_in  : divider start pulse and op presented with it
//   div_op_out           : latched op for the divider result mux
//   div_a/div_b          : latched dividend/divisor
//   div_flush            : divider freeze, tied 0
//   div_busy/div_finish  : divider status / done pulse
//   div_result           : divider result
//   ctrl_busy            : high whenever the FSM is not IDLE
// Optional feature macro: DIV_ZERO_BYPASS_EN (divide-by-zero answered
// directly without starting the divider).
module div_issue_ctrl
    import common::*;
#(
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    div_issue_ctrl_if.slave       bus,
    output logic                  div_start,
    output alu_op_type            div_op_in,
    output alu_op_type            div_op_out,
    output logic [XLEN_WIDTH-1:0] div_a,
    output logic [XLEN_WIDTH-1:0] div_b,
    output logic                  div_flush,
    input  logic                  div_busy,
    input  logic                  div_finish,
    input  logic [XLEN_WIDTH-1:0] div_result,
    output logic                  ctrl_busy
);

    if (NUM_REQ != 2) begin : g_num_req_check
        $error("div_issue_ctrl supports NUM_REQ == 2 only");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                state_q;
    logic                  rr_q;
    logic                  squash_q;
    alu_op_type            op_q;
    logic [XLEN_WIDTH-1:0] a_q;
    logic [XLEN_WIDTH-1:0] b_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  start_q;
    alu_op_type            op_in_q;
    logic                  wb_valid_q;
    logic [XLEN_WIDTH-1:0] wb_data_q;
    logic                  busy_q;

    logic                  sel;
    logic                  accept;
    logic [1:0]            ready;

    // Grant: rr_q breaks a tie, otherwise the single valid lane wins.
    always_comb begin
        sel   = (bus.req_valid == 2'b11) ? rr_q : bus.req_valid[1];
        ready = '0;
        if (state_q == IDLE && !flush && !div_busy) begin
            ready[sel] = bus.req_valid[sel];
        end
        accept        = |ready;
        bus.req_ready = ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            squash_q   <= 1'b0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            start_q    <= 1'b0;
            op_in_q    <= ALU_ADD;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            op_in_q <= ALU_ADD;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= bus.req_op[sel];
                        a_q    <= bus.req_a[sel];
                        b_q    <= bus.req_b[sel];
                        tag_q  <= bus.req_tag[sel];
                        rr_q   <= ~sel;
                        busy_q <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                        if (bus.req_b[sel] == '0) begin
                            state_q    <= HOLD;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= (bus.req_op[sel] == ALU_DIV ||
                                           bus.req_op[sel] == ALU_DIVU)
                                          ? '1 : bus.req_a[sel];
                        end else begin
                            state_q <= ISSUE;
                            start_q <= 1'b1;
                            op_in_q <= bus.req_op[sel];
                        end
`else
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                        op_in_q <= bus.req_op[sel];
`endif
                    end
                end
                ISSUE: begin
                    // The start pulse is already out; a flush here only
                    // marks the result for discard.
                    state_q <= WAIT;
                    if (flush) squash_q <= 1'b1;
                end
                WAIT: begin
                    if (div_finish) begin
                        wb_data_q <= div_result;
                        if (squash_q || flush) begin
                            squash_q <= 1'b0;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q    <= HOLD;
                            wb_valid_q <= 1'b1;
                        end
                    end else if (flush) begin
                        squash_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.wb_ready || flush) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_start    = start_q;
    assign div_op_in    = op_in_q;
    assign div_op_out   = op_q;
    assign div_a        = a_q;
    assign div_b        = b_q;
    assign div_flush    = 1'b0;
    assign ctrl_busy    = busy_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_tag   = tag_q;
    assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 34-cycle divider.
module tb_div_issue_ctrl;
    import common::*;

    localparam int unsigned TAG_W = 6;
`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
    localparam int ZST  = -1;
`else
    localparam int ZLAT = 36;
    localparam int ZST  = 1;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  div_start;
    alu_op_type            div_op_in;
    alu_op_type            div_op_out;
    logic [XLEN_WIDTH-1:0] div_a;
    logic [XLEN_WIDTH-1:0] div_b;
    logic                  div_flush;
    logic                  div_busy;
    logic                  div_finish;
    logic [XLEN_WIDTH-1:0] div_result;
    logic                  ctrl_busy;

    div_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    div_issue_ctrl #(.TAG_W(TAG_W), .NUM_REQ(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .bus        (bus.slave),
        .div_start  (div_start),
        .div_op_in  (div_op_in),
        .div_op_out (div_op_out),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_flush  (div_flush),
        .div_busy   (div_busy),
        .div_finish (div_finish),
        .div_result (div_result),
        .ctrl_busy  (ctrl_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    // Divider model: finish pulse 34 cycles after the start cycle.
    function automatic logic [31:0] ref_div(alu_op_type op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: r = (b == 0) ? a : a % b;
            ALU_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            ALU_REM: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = $signed(a) % $signed(b);
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    logic [5:0]  cnt;
    alu_op_type  m_op;
    logic [31:0] m_a, m_b;
    always @(posedge clk) begin
        if (!reset_n) begin
            div_busy   <= 1'b0;
            div_finish <= 1'b0;
            div_result <= '0;
            cnt        <= '0;
        end else begin
            div_finish <= 1'b0;
            if (div_start) begin
                div_busy <= 1'b1;
                cnt      <= 6'd32;
                m_op     <= div_op_in;
                m_a      <= div_a;
                m_b      <= div_b;
            end else if (div_busy) begin
                if (cnt == 0) begin
                    div_busy   <= 1'b0;
                    div_finish <= 1'b1;
                    div_result <= ref_div(m_op, m_a, m_b);
                end else begin
                    cnt <= cnt - 6'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int lane, input alu_op_type op, input logic [31:0] a,
                             input logic [31:0] b, input logic [5:0] tag);
        bus.req_valid[lane] = 1'b1;
        bus.req_op[lane]    = op;
        bus.req_a[lane]     = a;
        bus.req_b[lane]     = b;
        bus.req_tag[lane]   = tag;
    endtask

    // Call right after a posedge; returns just after the accepting edge.
    task automatic wait_accept(input int lane, output int t, output logic [1:0] rdy);
        bit ok = 0;
        t = -1;
        rdy = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready[lane] && bus.req_valid[lane]) begin
                t = cyc;
                rdy = bus.req_ready;
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[lane] = 1'b0;
    endtask

    task automatic wait_wb(output int t, output int t_start);
        bit ok = 0;
        t = -1;
        t_start = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (div_start) t_start = cyc;
            if (bus.wb_valid) begin
                t = cyc;
                ok = 1;
                break;
            end
        end
        chk("wb_timeout", 32'(ok), 32'd1);
    endtask

    task automatic watch_idle(output bit saw_wb, output int t_idle, output bit rdy_err);
        bit ok = 0;
        saw_wb = 0;
        rdy_err = 0;
        t_idle = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.wb_valid) saw_wb = 1;
            if (!ctrl_busy) begin
                t_idle = cyc;
                ok = 1;
                break;
            end
            if (|bus.req_ready) rdy_err = 1;
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        int          lane;
        alu_op_type  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_start;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, tw, ts, ti, r;
        logic [1:0] rdy;
        bit saw, rerr, stable;

        vecs[0] = '{0, ALU_DIV,  32'd100,        32'd7,          6'd5,  32'd14,         36,   1};
        vecs[1] = '{1, ALU_DIVU, 32'd5,          32'd0,          6'd9,  32'hFFFF_FFFF,  ZLAT, ZST};
        vecs[2] = '{0, ALU_REM,  32'hFFFF_FFF9,  32'd2,          6'd3,  32'hFFFF_FFFF,  36,   1};
        vecs[3] = '{1, ALU_REMU, 32'd17,         32'd5,          6'd6,  32'd2,          36,   1};
        vecs[4] = '{0, ALU_DIV,  32'hFFFF_FFEC,  32'd3,          6'd12, 32'hFFFF_FFFA,  36,   1};
        vecs[5] = '{1, ALU_REM,  32'd9,          32'd0,          6'd33, 32'd9,          ZLAT, ZST};
        vecs[6] = '{0, ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  6'd63, 32'h8000_0000,  36,   1};

        bus.req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            bus.req_op[i]  = ALU_ADD;
            bus.req_a[i]   = '0;
            bus.req_b[i]   = '0;
            bus.req_tag[i] = '0;
        end
        bus.wb_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid",  32'(bus.wb_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
        chk("rst_wb_data",   bus.wb_data, 32'd0);
        chk("rst_wb_tag",    32'(bus.wb_tag), 32'd0);
        chk("rst_div_ab",    div_a | div_b, 32'd0);
        chk("rst_ops",       32'({div_op_in, div_op_out}), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_div_flush", 32'(div_flush), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single requests
        foreach (vecs[k]) begin
            drive_req(vecs[k].lane, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].tag);
            wait_accept(vecs[k].lane, t, rdy);
            wait_wb(tw, ts);
            chk($sformatf("v%0d_lat", k),   32'(tw - t), 32'(vecs[k].exp_lat));
            chk($sformatf("v%0d_start", k), 32'((ts < 0) ? -1 : ts - t), 32'(vecs[k].exp_start));
            chk($sformatf("v%0d_data", k),  bus.wb_data, vecs[k].exp_data);
            chk($sformatf("v%0d_tag", k),   32'(bus.wb_tag), 32'(vecs[k].tag));
            chk($sformatf("v%0d_opout", k), 32'(div_op_out), 32'(vecs[k].op));
            @(negedge clk);
            chk($sformatf("v%0d_wb_drop", k), 32'({bus.wb_valid, ctrl_busy}), 32'd0);
            @(posedge clk);
            #1;
        end

        // Both lanes valid: lane0 first, then rr_ptr favours lane1
        drive_req(0, ALU_REMU, 32'd17, 32'd5, 6'd1);
        drive_req(1, ALU_DIVU, 32'd9, 32'd3, 6'd2);
        wait_accept(0, t, rdy);
        chk("rr_first_grant", 32'(rdy), 32'b01);
        drive_req(0, ALU_DIV, 32'd100, 32'd7, 6'd7);
        wait_wb(tw, ts);
        chk("rr_wb1", {bus.wb_data[25:0], bus.wb_tag}, {26'd2, 6'd1});
        wait_accept(1, t, rdy);
        chk("rr_second_grant", 32'(rdy), 32'b10);
        wait_wb(tw, ts);
        chk("rr_wb2", {bus.wb_data[25:0], bus.wb_tag}, {26'd3, 6'd2});
        wait_accept(0, t, rdy);
        wait_wb(tw, ts);
        chk("rr_wb3", {bus.wb_data[25:0], bus.wb_tag}, {26'd14, 6'd7});
        @(posedge clk);
        #1;

        // Flush during WAIT with lane1 pending
        drive_req(0, ALU_DIV, 32'hFFFF_FFEC, 32'd3, 6'd4);
        wait_accept(0, t, rdy);
        drive_req(1, ALU_DIVU, 32'd9, 32'd3, 6'd8);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        watch_idle(saw, ti, rerr);
        chk("flushw_no_wb",   32'(saw), 32'd0);
        chk("flushw_idle_at", 32'(ti - t), 32'd36);
        chk("flushw_no_rdy",  32'(rerr), 32'd0);
        chk("flushw_reacc",   32'(bus.req_ready), 32'b10);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        wait_wb(tw, ts);
        chk("flushw_next", {bus.wb_data[25:0], bus.wb_tag}, {26'd3, 6'd8});
        @(posedge clk);
        #1;

        // Flush during ISSUE: start still pulses, result dropped
        drive_req(0, ALU_DIVU, 32'd50, 32'd5, 6'd10);
        wait_accept(0, t, rdy);
        flush = 1'b1;
        @(negedge clk);
        chk("flushi_start", 32'(div_start), 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        watch_idle(saw, ti, rerr);
        chk("flushi_no_wb",   32'(saw), 32'd0);
        chk("flushi_idle_at", 32'(ti - t), 32'd36);
        @(posedge clk);
        #1;

        // Writeback stall: REM -7/2 held 5 cycles
        bus.wb_ready = 1'b0;
        drive_req(1, ALU_REM, 32'hFFFF_FFF9, 32'd2, 6'd21);
        wait_accept(1, t, rdy);
        wait_wb(tw, ts);
        stable = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (!(bus.wb_valid && bus.wb_data == 32'hFFFF_FFFF && bus.wb_tag == 6'd21 &&
                  div_op_out == ALU_REM && ctrl_busy)) stable = 0;
        end
        @(posedge clk);
        #1 bus.wb_ready = 1'b1;
        @(negedge clk);
        if (!(bus.wb_valid && bus.wb_data == 32'hFFFF_FFFF)) stable = 0;
        chk("stall_stable", 32'(stable), 32'd1);
        @(negedge clk);
        chk("stall_release", 32'({bus.wb_valid, ctrl_busy}), 32'd0);
        @(posedge clk);
        #1;

        // Flush in HOLD drops wb_valid
        bus.wb_ready = 1'b0;
        drive_req(0, ALU_DIVU, 32'd9, 32'd3, 6'd11);
        wait_accept(0, t, rdy);
        wait_wb(tw, ts);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flushh_drop", 32'({bus.wb_valid, ctrl_busy}), 32'd0);
        bus.wb_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset during WAIT
        drive_req(0, ALU_DIV, 32'd100, 32'd7, 6'd13);
        wait_accept(0, t, rdy);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        r = cyc;
        chk("wrst_outputs", 32'({bus.wb_valid, div_start, ctrl_busy, div_busy}), 32'd0);
        chk("wrst_data",    div_a | div_b | bus.wb_data | 32'(bus.wb_tag) | 32'(div_op_out), 32'd0);
        @(posedge clk);
        #1;
        drive_req(1, ALU_DIVU, 32'd17, 32'd5, 6'd14);
        wait_accept(1, t2, rdy);
        chk("wrst_reaccept", 32'(t2 - r), 32'd1);
        wait_wb(tw, ts);
        chk("wrst_wb", {bus.wb_data[25:0], bus.wb_tag}, {26'd3, 6'd14});
        chk("wrst_lat", 32'(tw - t2), 32'd36);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
